pipelined_adder: RTL and testbench
==================================

// Module: pipelined_adder
// PURPOSE
//  Parametrised, carry-pipelined add/subtract unit; successor to the fixed 16-bit registered adder.
//  Splits the carry chain into CHUNK-bit stages, one register stage per chunk, to close timing at wide WIDTH.
//  Adds a valid/ready handshake with backpressure, signed/unsigned mode, subtraction, and a zero flag.
//  Sits between an operand-issue stage and a result consumer in the datapath.
// PARAMETERS
//  WIDTH   32  operand/result width in bits; must be a multiple of CHUNK
//  CHUNK   8   bits resolved per pipeline stage; NSTG = WIDTH/CHUNK (>=1) register stages
// PORTS
//  clk        in   1      single clock; all logic on rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      unit can accept a beat this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (add) / borrow-in (sub)
//  sub        in   1      1: A-B-cin, 0: A+B+cin
//  is_signed  in   1      1: two's-complement overflow rules, 0: unsigned rules
//  out_valid  out  1      result beat valid
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result
//  cout       out  1      raw carry out of MSB (for sub: borrow = ~cout)
//  overflow   out  1      overflow per is_signed/sub rules below
//  zero       out  1      sum == 0 (after saturation, if enabled)
// BEHAVIOUR
//  - Reset: all stage valid bits 0; out_valid=0, sum=0, cout=0, overflow=0, zero=0. Reset mid-operation drops all in-flight beats.
//  - Stall enable: adv = !out_valid | out_ready; in_ready = adv. Beat accepted when in_valid & in_ready.
//  - adv=0 freezes every stage (data and valid); adv=1 shifts all stages by one. Bubbles are not compacted.
//  - Latency: accepted beat appears on out_valid exactly NSTG cycles later with no stall; +1 per stalled cycle.
//  - Throughput: one beat per cycle while out_ready=1. Outputs hold stable while out_valid & !out_ready.
//  - Datapath: b_eff = sub ? ~b : b; c0 = sub ? ~cin : cin. Stage k adds chunk k of a,b_eff with carry from stage k-1;
//    upper operand chunks and sub/is_signed/sign bits ride delay registers alongside.
//  - cout = carry out of bit WIDTH-1.
//  - overflow: signed: a[MSB]==b_eff[MSB] && sum[MSB]!=a[MSB]; unsigned add: cout; unsigned sub: ~cout.
//    Overflow uses the raw (pre-saturation) sum, computed in the final stage.
//  - Wrap-around: without saturation, sum is the low WIDTH bits (e.g. FFFF_FFFF+1 -> 0, cout=1).
//  - Signals with in_valid=0 are don't-care; stage registers may load them but valid stays 0.
// CONFIGURATION
//  Macro PIPELINED_ADDER_SAT_EN:
//   defined: on overflow, sum saturates. Signed: a[MSB]=0 -> 0x7F..F, a[MSB]=1 -> 0x80..0.
//     Unsigned add -> all ones; unsigned sub -> 0. cout/overflow still report raw result; zero reflects saturated sum.
//   undefined: sum is always the wrapped raw result; no saturation logic present.
// STRUCTURE
//  Package adder_pkg: localparam NSTG derivation helper; typedef struct stage_t {valid, sub, is_signed, sign_a,
//  sign_b, carry, partial sum, pending a/b chunks}; saturation constants (SMAX/SMIN/UMAX) as functions of WIDTH.
//  Sub-module adder_chunk_stage: one CHUNK-bit add plus pipeline register with enable; instantiated NSTG times via generate.
//  Top handles handshake, operand inversion, final-stage flags and optional saturation.
// TESTING  (WIDTH=32, CHUNK=8, NSTG=4)
//  1 Reset then add 0x0000_0001+0x0000_0002, cin=0 -> 4 cycles later sum=0x0000_0003, cout=0, ovf=0, zero=0.
//  2 Carry ripples all chunks: 0xFFFF_FFFF+0x0000_0001, unsigned -> sum=0, cout=1, ovf=1, zero=1 (SAT_EN: sum=0xFFFF_FFFF, zero=0).
//  3 Signed ovf: 0x7FFF_FFFF+1, is_signed=1 -> sum=0x8000_0000, ovf=1, cout=0 (SAT_EN: sum=0x7FFF_FFFF).
//  4 Sub: 5-7 unsigned, sub=1, cin=0 -> sum=0xFFFF_FFFE, cout=0, ovf=1 (SAT_EN: sum=0); signed -> same sum, ovf=0.
//  5 Backpressure: 8 back-to-back beats, out_ready low cycles 6-9 -> in_ready=0 in those cycles, no beat lost/duplicated, order kept, output held stable.
//  6 Assert rst with 3 beats in flight -> next cycle out_valid=0, all flags 0; next accepted beat emerges after exactly 4 cycles.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and helpers for pipelined_adder: stage-count derivation, per-stage
// control bundle and saturation constants.
package adder_pkg;

  // Upper bound on WIDTH for the saturation constant helpers.
  localparam int unsigned MaxWidth = 256;

  // Number of carry-pipeline stages; never less than one. CHUNK must be non-zero.
  function automatic int unsigned num_stages(input int unsigned width, input int unsigned chunk);
    return (width / chunk < 1) ? 1 : width / chunk;
  endfunction

  // Control bits that ride alongside the partial sum through every stage.
  // Operand chunks and the partial sum are WIDTH-dependent, so they travel as
  // separate vectors next to this bundle.
  typedef struct packed {
    logic valid;
    logic sub;
    logic is_signed;
    logic sign_a;
    logic sign_b;
    logic carry;
  } stage_t;

  function automatic logic [MaxWidth-1:0] sat_umax(input int unsigned width);
    logic [MaxWidth-1:0] ones;
    ones = '1;
    return ones >> (MaxWidth - width);
  endfunction

  function automatic logic [MaxWidth-1:0] sat_smax(input int unsigned width);
    return sat_umax(width) >> 1;
  endfunction

  function automatic logic [MaxWidth-1:0] sat_smin(input int unsigned width);
    logic [MaxWidth-1:0] one;
    one = 1;
    return one << (width - 1);
  endfunction

endpackage

// File: rtl/adder_chunk_stage.sv
// One CHUNK-bit slice of the carry pipeline: adds operand chunk Idx with the incoming
// carry, merges it into the partial sum and registers everything under a shared enable.
module adder_chunk_stage
  import adder_pkg::*;
#(
  parameter int unsigned Width = 32,
  parameter int unsigned Chunk = 8,
  parameter int unsigned Idx   = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  stage_t           ctrl_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic [Width-1:0] sum_i,
  output stage_t           ctrl_o,
  output logic [Width-1:0] a_o,
  output logic [Width-1:0] b_o,
  output logic [Width-1:0] sum_o
);

  localparam int unsigned Lo = Idx * Chunk;

  logic [Chunk:0]   chunk_sum;
  stage_t           ctrl_d, ctrl_q;
  logic [Width-1:0] a_q, b_q;
  logic [Width-1:0] sum_d, sum_q;

  assign chunk_sum = {1'b0, a_i[Lo +: Chunk]} + {1'b0, b_i[Lo +: Chunk]} +
                     {{Chunk{1'b0}}, ctrl_i.carry};

  always_comb begin
    sum_d              = sum_i;
    sum_d[Lo +: Chunk] = chunk_sum[Chunk-1:0];
    ctrl_d             = ctrl_i;
    ctrl_d.carry       = chunk_sum[Chunk];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
    end else if (en_i) begin
      ctrl_q <= ctrl_d;
      a_q    <= a_i;
      b_q    <= b_i;
      sum_q  <= sum_d;
    end
  end

  assign ctrl_o = ctrl_q;
  assign a_o    = a_q;
  assign b_o    = b_q;
  assign sum_o  = sum_q;

endmodule

// File: rtl/pipelined_adder.sv
// Carry-pipelined add/subtract unit with valid/ready backpressure and result flags.
// Optional saturation on overflow is enabled by defining PIPELINED_ADDER_SAT_EN.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned NSTG = num_stages(WIDTH, CHUNK);

  logic             adv;
  logic [WIDTH-1:0] b_eff;

  stage_t           ctrl_pipe [NSTG+1];
  logic [WIDTH-1:0] a_pipe    [NSTG+1];
  logic [WIDTH-1:0] b_pipe    [NSTG+1];
  logic [WIDTH-1:0] sum_pipe  [NSTG+1];

  // Whole pipeline moves in lockstep; bubbles are not compacted.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  assign b_eff    = sub ? ~b : b;

  assign ctrl_pipe[0] = '{valid:     in_valid,
                          sub:       sub,
                          is_signed: is_signed,
                          sign_a:    a[WIDTH-1],
                          sign_b:    b_eff[WIDTH-1],
                          carry:     sub ? ~cin : cin};
  assign a_pipe[0]    = a;
  assign b_pipe[0]    = b_eff;
  assign sum_pipe[0]  = '0;

  for (genvar k = 0; k < NSTG; k++) begin : g_stage
    adder_chunk_stage #(
      .Width(WIDTH),
      .Chunk(CHUNK),
      .Idx  (k)
    ) u_stage (
      .clk_i (clk),
      .rst_i (rst),
      .en_i  (adv),
      .ctrl_i(ctrl_pipe[k]),
      .a_i   (a_pipe[k]),
      .b_i   (b_pipe[k]),
      .sum_i (sum_pipe[k]),
      .ctrl_o(ctrl_pipe[k+1]),
      .a_o   (a_pipe[k+1]),
      .b_o   (b_pipe[k+1]),
      .sum_o (sum_pipe[k+1])
    );
  end

  stage_t           last;
  logic [WIDTH-1:0] raw_sum;
  logic [WIDTH-1:0] res_sum;
  logic             raw_ovf;

  assign last    = ctrl_pipe[NSTG];
  assign raw_sum = sum_pipe[NSTG];

  always_comb begin
    if (last.is_signed) begin
      raw_ovf = (last.sign_a == last.sign_b) && (raw_sum[WIDTH-1] != last.sign_a);
    end else begin
      raw_ovf = last.sub ? ~last.carry : last.carry;
    end
  end

`ifdef PIPELINED_ADDER_SAT_EN
  localparam logic [MaxWidth-1:0] UMaxFull = sat_umax(WIDTH);
  localparam logic [MaxWidth-1:0] SMaxFull = sat_smax(WIDTH);
  localparam logic [MaxWidth-1:0] SMinFull = sat_smin(WIDTH);
  localparam logic [WIDTH-1:0]    UMax     = UMaxFull[WIDTH-1:0];
  localparam logic [WIDTH-1:0]    SMax     = SMaxFull[WIDTH-1:0];
  localparam logic [WIDTH-1:0]    SMin     = SMinFull[WIDTH-1:0];

  always_comb begin
    res_sum = raw_sum;
    if (raw_ovf) begin
      if (last.is_signed) begin
        res_sum = last.sign_a ? SMin : SMax;
      end else begin
        res_sum = last.sub ? '0 : UMax;
      end
    end
  end
`else
  assign res_sum = raw_sum;
`endif

  // Outputs read zero whenever no beat is presented, including straight after reset.
  assign out_valid = last.valid;
  assign sum       = last.valid ? res_sum : '0;
  assign cout      = last.valid & last.carry;
  assign overflow  = last.valid & raw_ovf;
  assign zero      = last.valid & (res_sum == '0);

  // Operands leaving the final stage have already been consumed.
  logic unused_ops;
  assign unused_ops = ^{a_pipe[NSTG], b_pipe[NSTG]};

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=32, CHUNK=8): directed vectors with
// hand-computed results, backpressure, latency and mid-flight reset.
module tb_pipelined_adder;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, cin, sub, is_signed;
  logic        out_valid, out_ready, cout, overflow, zero;
  logic [31:0] a, b, sum;

  always #5 clk = ~clk;

  pipelined_adder #(
    .WIDTH(32),
    .CHUNK(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .is_signed(is_signed),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow),
    .zero     (zero)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin, sub, sgn;
    logic [31:0] sum;
    logic        cout, ovf, zero;
    logic [31:0] sat_sum;
    logic        sat_zero;
  } vec_t;

  typedef struct {
    logic [31:0] sum;
    logic        cout, ovf, zero;
  } exp_t;

  vec_t vecs [11];
  exp_t exp_q [$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   stall_lo = -1;
  int   stall_hi = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Consumer: out_ready drops inside the programmed stall window.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
    end
  end

  // Monitor: pops the scoreboard on each transferred beat, checks hold and in_ready.
  initial begin
    logic        hold_v;
    logic [31:0] hold_sum;
    logic [31:0] hold_flags;
    exp_t        e;
    hold_v = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          chk32("hold_sum", sum, hold_sum);
          chk32("hold_flags", {29'b0, cout, overflow, zero}, hold_flags);
        end
        if (!out_ready) chk1("in_ready_stall", in_ready, ~out_valid);
        hold_v     = out_valid && !out_ready;
        hold_sum   = sum;
        hold_flags = {29'b0, cout, overflow, zero};
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk1("spurious_beat", out_valid, 1'b0);
          end else begin
            e = exp_q.pop_front();
            chk32("sum", sum, e.sum);
            chk1("cout", cout, e.cout);
            chk1("overflow", overflow, e.ovf);
            chk1("zero", zero, e.zero);
          end
        end
      end
    end
  end

  task automatic send(input int i);
    exp_t e;
    int   waits;
    @(negedge clk);
    a         = vecs[i].a;
    b         = vecs[i].b;
    cin       = vecs[i].cin;
    sub       = vecs[i].sub;
    is_signed = vecs[i].sgn;
    in_valid  = 1'b1;
    #1;
    waits = 0;
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!in_ready) chk1("accept_timeout", in_ready, 1'b1);
`ifdef PIPELINED_ADDER_SAT_EN
    e.sum  = vecs[i].sat_sum;
    e.zero = vecs[i].sat_zero;
`else
    e.sum  = vecs[i].sum;
    e.zero = vecs[i].zero;
`endif
    e.cout = vecs[i].cout;
    e.ovf  = vecs[i].ovf;
    exp_q.push_back(e);
  endtask

  task automatic lat_check(input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      #3;
      k++;
    end while (!out_valid && k < 20);
    chk32(name, k, 32'd4);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(negedge clk);
      in_valid = 1'b0;
      k++;
    end
    chk32("drain_empty", exp_q.size(), 32'd0);
  endtask

  task automatic check_idle(input string name);
    chk1({name, "_out_valid"}, out_valid, 1'b0);
    chk32({name, "_sum"}, sum, 32'h0);
    chk32({name, "_flags"}, {29'b0, cout, overflow, zero}, 32'h0);
    chk1({name, "_in_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    //           a             b             cin   sub   sgn   sum           cout  ovf   zero  sat_sum       sat_zero
    vecs[0]  = '{32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 32'h0000_0003, 1'b0};
    vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0};
    vecs[2]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b0};
    vecs[3]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b1};
    vecs[4]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b0};
    vecs[5]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 32'h8000_0000, 1'b0};
    vecs[6]  = '{32'h00FF_00FF, 32'h0001_FF01, 1'b1, 1'b0, 1'b0, 32'h0101_0001, 1'b0, 1'b0, 1'b0, 32'h0101_0001, 1'b0};
    vecs[7]  = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 1'b0, 32'h0000_0006, 1'b1, 1'b0, 1'b0, 32'h0000_0006, 1'b0};
    vecs[8]  = '{32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b1};
    vecs[9]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b0};
    vecs[10] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    is_signed = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check_idle("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single beat latency after reset.
    send(0);
    lat_check("latency_first");
    drain();

    // All directed vectors back-to-back at full throughput.
    for (int i = 0; i < 11; i++) send(i);
    drain();

    // Eight-beat burst with consumer stalled for four cycles.
    stall_lo = cyc + 6;
    stall_hi = cyc + 9;
    for (int i = 0; i < 8; i++) send(i);
    drain();

    // Reset with three beats in flight; they must vanish.
    for (int i = 3; i < 6; i++) send(i);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    exp_q.delete();
    @(negedge clk);
    #2;
    check_idle("mid_reset");
    #1;
    rst = 1'b0;
    send(1);
    lat_check("latency_after_rst");
    drain();

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
